regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: NUM_REGS, default 8, number of architectural registers; fixed at 8 for this core.
REQ-002 Parameter: DATA_W, default 8, writeback data width.
REQ-003 Ports SHALL be exactly (name  direction  width  meaning):
- Clk  in  1  single clock; all state updates on its rising edge.
- Reset_n  in  1  reset, synchronous, active-low.
- AluValid  in  1  ALU writeback request.
- AluAddr  in  3  ALU destination register.
- AluData  in  8  ALU result.
- AluReady  out  1  ALU request accepted this cycle.
- MemValid  in  1  load writeback request.
- MemAddr  in  3  load destination register.
- MemData  in  8  load data.
- MemReady  out  1  load request accepted this cycle.
- IssueValid  in  1  instruction with a destination register issued this cycle.
- IssueAddr  in  3  destination of the issuing instruction.
- Flush  in  1  pipeline flush; clears the scoreboard.
- WriteEnable  out  1  register-file write enable, registered.
- WriteAddr  out  3  register-file write address, registered.
- WriteData  out  8  register-file write data, registered.
- BusyMask  out  8  bit r = 1: write to register r pending.
- CollisionCount  out  8  saturating count of cycles with both requesters valid.

Function
REQ-004 Transfer on a requester SHALL occur when its Valid and Ready are both 1 in the same cycle.
REQ-005 AluReady and MemReady SHALL be combinational, never both 1, and 0 whenever the corresponding Valid is 0.
REQ-006 Only one valid requester: it SHALL be granted that cycle.
REQ-007 Both valid: grant SHALL go to the requester named by round-robin pointer RrPtr, reset value WB_ALU.
- RrPtr SHALL flip to the other source only after a contended grant.
- An uncontended grant SHALL leave RrPtr unchanged.
REQ-008 A requester SHALL hold Valid, Addr and Data stable until its transfer; the arbiter does not buffer ungranted requests.
REQ-009 Write-port latency SHALL be 1 cycle: a transfer in cycle N drives WriteEnable=1 with the granted Addr/Data in cycle N+1.
- WriteEnable SHALL be 0 in any cycle following a non-transfer cycle.
- Back-to-back transfers SHALL give one write per cycle, no bubble.
REQ-010 A transfer with Addr=0 SHALL complete the handshake but SHALL NOT assert WriteEnable (R0 is hardwired zero).
REQ-011 BusyMask[r] SHALL be set at the edge where IssueValid=1 and IssueAddr=r, r!=0; IssueAddr=0 SHALL be ignored.
REQ-012 BusyMask[r] SHALL be cleared at the edge where WriteEnable=1 and WriteAddr=r, i.e. when the register file commits the data.
REQ-013 Set and clear of the same bit at the same edge: set SHALL win.
REQ-014 Flush=1 SHALL clear all BusyMask bits at that edge, overriding any set.
- Flush SHALL NOT cancel a handshake or a WriteEnable already in flight.
REQ-015 BusyMask[0] SHALL be constant 0.
REQ-016 CollisionCount SHALL increment by 1 each cycle AluValid=MemValid=1 and SHALL saturate at 255, never wrapping.

Reset
REQ-017 Reset_n=0 at an edge SHALL force the following registers to 0: WriteEnable, WriteAddr, WriteData, BusyMask and CollisionCount. RrPtr SHALL reset to WB_ALU.
REQ-018 While Reset_n=0, AluReady and MemReady SHALL be 0 and no transfer SHALL occur.
REQ-019 Reset asserted the cycle after a transfer SHALL suppress that pending WriteEnable.

Structure
REQ-020 Package regfile_pkg SHALL hold the shared definitions:
- Constants: REG_COUNT=8, REG_ADDR_W=3, REG_DATA_W=8.
- Typedef wb_src_e: WB_ALU, WB_MEM.
REQ-021 Arbitration SHALL live in one sub-module, wb_rr_arb2 (2-way round-robin: request pair in; grant pair and pointer out). Scoreboard and write register SHALL stay in regfile_wb_arbiter.

Verification
REQ-022 The bench SHALL cover:
- Alu only, Addr=3, Data=0x5A -> AluReady=1 same cycle; next cycle WriteEnable=1, WriteAddr=3, WriteData=0x5A.
- Both valid for 4 cycles after reset, requesters re-presenting new data each time -> grants ALU, MEM, ALU, MEM; CollisionCount=4.
- IssueValid on Addr=5, later Mem writes Addr=5 -> BusyMask=0x20 until the edge after WriteEnable, then 0x00.
- Same edge: WriteEnable commits Addr=2 and IssueValid Addr=2 -> BusyMask[2] stays 1; next: Alu Addr=0, Data=0xFF -> handshake completes, WriteEnable stays 0.
- BusyMask=0x7E, then Flush=1 with IssueValid Addr=4 -> BusyMask=0x00; Reset_n=0 right after a transfer -> WriteEnable stays 0, all outputs 0.
- Hold both valid for 300 cycles -> CollisionCount saturates at 255.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter: sizes and
// the writeback-source encoding used by the round-robin pointer.
package regfile_pkg;

  localparam int REG_COUNT  = 8;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  function automatic wb_src_e wb_other(input wb_src_e src);
    return (src == WB_ALU) ? WB_MEM : WB_ALU;
  endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter. Bit WB_ALU/WB_MEM of req/grant selects the
// source; the pointer only advances after a contended cycle.
module wb_rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output wb_src_e    ptr
);

  wb_src_e ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (reset_n) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (ptr_reg == WB_ALU) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // A contended cycle always grants exactly the pointed-at source, so the
  // pointer simply hands priority to the other side afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_reg <= WB_ALU;
    end else if (req == 2'b11) begin
      ptr_reg <= wb_other(ptr_reg);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file: merges ALU and load
// writebacks onto one registered write port and tracks pending writes.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int DATA_W   = REG_DATA_W
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  AluValid,
  input  logic [REG_ADDR_W-1:0] AluAddr,
  input  logic [DATA_W-1:0]     AluData,
  output logic                  AluReady,
  input  logic                  MemValid,
  input  logic [REG_ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0]     MemData,
  output logic                  MemReady,
  input  logic                  IssueValid,
  input  logic [REG_ADDR_W-1:0] IssueAddr,
  input  logic                  Flush,
  output logic                  WriteEnable,
  output logic [REG_ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0]     WriteData,
  output logic [NUM_REGS-1:0]   BusyMask,
  output logic [7:0]            CollisionCount
);

  logic [1:0]            grant;
  wb_src_e               rr_ptr;
  logic                  transfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_data;

  logic                  we_reg;
  logic [REG_ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [NUM_REGS-1:0]   busy_reg;
  logic [NUM_REGS-1:0]   busy_next;
  logic [7:0]            coll_reg;

  wb_rr_arb2 u_arb (
    .clk     (Clk),
    .reset_n (Reset_n),
    .req     ({MemValid, AluValid}),
    .grant   (grant),
    .ptr     (rr_ptr)
  );

  assign AluReady = grant[WB_ALU];
  assign MemReady = grant[WB_MEM];
  assign transfer = AluReady | MemReady;

  assign sel_addr = MemReady ? MemAddr : AluAddr;
  assign sel_data = MemReady ? MemData : AluData;

  // Per-register scoreboard: flush beats set, set beats the commit-clear.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_r0
        assign busy_next[gi] = 1'b0;
      end else begin : g_rn
        assign busy_next[gi] = !Flush &&
          ((IssueValid && (IssueAddr == REG_ADDR_W'(gi))) ||
           (busy_reg[gi] && !(we_reg && (waddr_reg == REG_ADDR_W'(gi)))));
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      busy_reg  <= '0;
      coll_reg  <= '0;
    end else begin
      // R0 is hardwired zero: its handshake completes but never writes.
      we_reg <= transfer && (sel_addr != '0);
      if (transfer) begin
        waddr_reg <= sel_addr;
        wdata_reg <= sel_data;
      end
      busy_reg <= busy_next;
      if (AluValid && MemValid && (coll_reg != 8'hFF)) begin
        coll_reg <= coll_reg + 8'd1;
      end
    end
  end

  assign WriteEnable    = we_reg;
  assign WriteAddr      = waddr_reg;
  assign WriteData      = wdata_reg;
  assign BusyMask       = busy_reg;
  assign CollisionCount = coll_reg;

  a_contended_follows_ptr : assert property (
    @(posedge Clk) disable iff (!Reset_n)
    (AluValid && MemValid) |-> (AluReady == (rr_ptr == WB_ALU))
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the write port.
module tb_regfile_wb_arbiter;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       AluValid, MemValid, IssueValid, Flush;
  logic [2:0] AluAddr, MemAddr, IssueAddr;
  logic [7:0] AluData, MemData;
  logic       AluReady, MemReady, WriteEnable;
  logic [2:0] WriteAddr;
  logic [7:0] WriteData, BusyMask, CollisionCount;

  int checks = 0;
  int passes = 0;

  // Behavioural model state (value visible during the current cycle)
  int       m_turn_mem = 0;
  int       m_we = 0;
  int       m_waddr = 0;
  int       m_wdata = 0;
  bit [7:0] m_busy = 8'h00;
  int       m_coll = 0;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.NUM_REGS(8), .DATA_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .Flush(Flush),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .BusyMask(BusyMask), .CollisionCount(CollisionCount)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Compare every cycle at the falling edge, then advance the model to the
  // state it must hold after the coming rising edge.
  always @(negedge Clk) begin
    int  ga, gm, gaddr, gdata;
    bit  both;
    both = AluValid && MemValid;
    ga = 0;
    gm = 0;
    if (Reset_n) begin
      if (both) begin
        ga = (m_turn_mem == 0);
        gm = (m_turn_mem == 1);
      end else begin
        ga = AluValid;
        gm = MemValid;
      end
    end
    check("m_alu_ready", AluReady, ga);
    check("m_mem_ready", MemReady, gm);
    check("m_write_enable", WriteEnable, m_we);
    if (m_we != 0) begin
      check("m_write_addr", WriteAddr, m_waddr);
      check("m_write_data", WriteData, m_wdata);
    end
    check("m_busy_mask", BusyMask, m_busy);
    check("m_collision_count", CollisionCount, m_coll);

    if (!Reset_n) begin
      m_turn_mem = 0;
      m_we = 0;
      m_waddr = 0;
      m_wdata = 0;
      m_busy = 8'h00;
      m_coll = 0;
    end else begin
      if (m_we != 0) m_busy[m_waddr] = 1'b0;
      if (IssueValid && IssueAddr != 0) m_busy[IssueAddr] = 1'b1;
      if (Flush) m_busy = 8'h00;
      if (both && m_coll < 255) m_coll = m_coll + 1;
      if (both) m_turn_mem = 1 - m_turn_mem;
      gaddr = gm ? int'(MemAddr) : int'(AluAddr);
      gdata = gm ? int'(MemData) : int'(AluData);
      m_we = ((ga + gm) > 0 && gaddr != 0) ? 1 : 0;
      if (ga + gm > 0) begin
        m_waddr = gaddr;
        m_wdata = gdata;
      end
    end
  end

  initial begin
    bit a_fire, m_fire;
    Reset_n = 1'b0;
    AluValid = 0; AluAddr = 0; AluData = 0;
    MemValid = 0; MemAddr = 0; MemData = 0;
    IssueValid = 0; IssueAddr = 0; Flush = 0;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("reset_write_enable", WriteEnable, 0);
    check("reset_busy", BusyMask, 8'h00);
    check("reset_coll", CollisionCount, 0);
    step();
    Reset_n = 1'b1;

    // ALU-only write
    AluValid = 1; AluAddr = 3; AluData = 8'h5A;
    @(negedge Clk);
    check("alu_only_ready", AluReady, 1);
    step();
    AluValid = 0;
    @(negedge Clk);
    check("alu_only_we", WriteEnable, 1);
    check("alu_only_addr", WriteAddr, 3);
    check("alu_only_data", WriteData, 8'h5A);
    step();

    // Contention right after reset: ALU, MEM, ALU, MEM
    Reset_n = 0;
    step();
    Reset_n = 1;
    AluValid = 1; AluAddr = 1; AluData = 8'h10;
    MemValid = 1; MemAddr = 2; MemData = 8'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("rr_alu_ready", AluReady, (i % 2 == 0) ? 1 : 0);
      check("rr_mem_ready", MemReady, (i % 2 == 1) ? 1 : 0);
      step();
      if (i % 2 == 0) AluData = AluData + 8'd1;
      else MemData = MemData + 8'd1;
    end
    AluValid = 0; MemValid = 0;
    @(negedge Clk);
    check("rr_coll_count", CollisionCount, 4);
    step();

    // Scoreboard set then commit-clear on register 5
    IssueValid = 1; IssueAddr = 5;
    step();
    IssueValid = 0;
    @(negedge Clk);
    check("busy5_set", BusyMask, 8'h20);
    MemValid = 1; MemAddr = 5; MemData = 8'h55;
    step();
    MemValid = 0;
    @(negedge Clk);
    check("busy5_we", WriteEnable, 1);
    check("busy5_held", BusyMask, 8'h20);
    step();
    @(negedge Clk);
    check("busy5_clear", BusyMask, 8'h00);
    step();

    // Set wins over clear on register 2; then a write to R0
    AluValid = 1; AluAddr = 2; AluData = 8'h11;
    step();
    AluAddr = 0; AluData = 8'hFF;
    IssueValid = 1; IssueAddr = 2;
    @(negedge Clk);
    check("same_edge_we", WriteEnable, 1);
    check("same_edge_addr", WriteAddr, 2);
    check("r0_ready", AluReady, 1);
    step();
    AluValid = 0; IssueValid = 0;
    @(negedge Clk);
    check("same_edge_busy", BusyMask, 8'h04);
    check("r0_no_we", WriteEnable, 0);
    step();

    // Fill to 0x7E, then flush against a concurrent issue
    for (int a = 1; a <= 6; a++) begin
      IssueValid = 1; IssueAddr = 3'(a);
      step();
    end
    IssueValid = 0;
    @(negedge Clk);
    check("busy_7e", BusyMask, 8'h7E);
    Flush = 1; IssueValid = 1; IssueAddr = 4;
    step();
    Flush = 0; IssueValid = 0;
    @(negedge Clk);
    check("flush_busy", BusyMask, 8'h00);

    // Reset right after a transfer
    AluValid = 1; AluAddr = 3; AluData = 8'h33;
    step();
    Reset_n = 0;
    @(negedge Clk);
    check("reset_ready_low", AluReady, 0);
    step();
    AluValid = 0;
    Reset_n = 1;
    @(negedge Clk);
    check("post_reset_we", WriteEnable, 0);
    check("post_reset_addr", WriteAddr, 0);
    check("post_reset_data", WriteData, 0);
    check("post_reset_busy", BusyMask, 0);
    step();

    // Saturation of the collision counter
    AluValid = 1; AluAddr = 6; AluData = 8'h66;
    MemValid = 1; MemAddr = 7; MemData = 8'h77;
    repeat (300) step();
    AluValid = 0; MemValid = 0;
    @(negedge Clk);
    check("coll_saturate", CollisionCount, 255);
    step();

    // Randomized traffic; requesters hold until they transfer
    for (int n = 0; n < 2000; n++) begin
      @(negedge Clk);
      a_fire = AluValid && AluReady;
      m_fire = MemValid && MemReady;
      @(posedge Clk);
      #1;
      Reset_n = ($urandom_range(0, 63) != 0);
      if (!AluValid || a_fire) begin
        AluValid = ($urandom_range(0, 2) != 0);
        AluAddr = 3'($urandom_range(0, 7));
        AluData = 8'($urandom_range(0, 255));
      end
      if (!MemValid || m_fire) begin
        MemValid = ($urandom_range(0, 2) != 0);
        MemAddr = 3'($urandom_range(0, 7));
        MemData = 8'($urandom_range(0, 255));
      end
      IssueValid = ($urandom_range(0, 3) == 0);
      IssueAddr = 3'($urandom_range(0, 7));
      Flush = ($urandom_range(0, 31) == 0);
    end
    @(negedge Clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
